fractal_sync_node: RTL and testbench

FRACTAL_SYNC_NODE -- requirements
Module: fractal_sync_node

---
 rtl/fractal_sync_pkg.sv | 21 ++
 rtl/fractal_sync_arb.sv | 11 +
 rtl/fractal_sync_node.sv | 155 +++++++++++++++
 tb/tb_fractal_sync_node.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fractal_sync_pkg.sv
// Fractal barrier node: shared id state encoding and per-id record.
// Records are sized for the largest supported node and zero-extended.
package fractal_sync_pkg;

  localparam int MAX_PORTS = 16;
  localparam int MAX_AGGR  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PEND    = 2'd2,
    ST_WAIT    = 2'd3
  } id_state_e;

  typedef struct packed {
    id_state_e              state;
    logic [MAX_PORTS-1:0]   mask;
    logic [MAX_AGGR-1:0]    aggr;
  } id_rec_t;

endpackage

// File: rtl/fractal_sync_arb.sv
// Fixed-priority selector: lowest-index request wins.
module fractal_sync_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  assign gnt_o = req_i & ~(req_i - N'(1));

endmodule

// File: rtl/fractal_sync_node.sv
// Fractal barrier node: merges child arrivals per id, completes
// locally at the root level or forwards one barrier to the parent.
module fractal_sync_node
  import fractal_sync_pkg::*;
#(
  parameter int N_PORTS    = 2,
  parameter int AGGR_WIDTH = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [N_PORTS-1:0]                  child_sync_i,
  input  logic [N_PORTS-1:0][AGGR_WIDTH-1:0]  child_aggr_i,
  input  logic [N_PORTS-1:0][ID_WIDTH-1:0]    child_id_i,
  output logic [N_PORTS-1:0]                  child_wake_o,
  output logic [N_PORTS-1:0]                  child_error_o,
  output logic                                parent_sync_o,
  output logic [AGGR_WIDTH-2:0]               parent_aggr_o,
  output logic [ID_WIDTH-1:0]                 parent_id_o,
  input  logic                                parent_wake_i,
  input  logic                                parent_error_i
);

  localparam int N_IDS = 2 ** ID_WIDTH;
  localparam logic [MAX_PORTS-1:0] FULL =
    MAX_PORTS'({N_PORTS{1'b1}});

  id_rec_t rec_q   [N_IDS];
  id_rec_t rec_mid [N_IDS];
  id_rec_t rec_d   [N_IDS];

  logic [N_PORTS-1:0]    wake_d, wake_q;
  logic [N_PORTS-1:0]    err_d, err_q;
  logic                  sync_d, sync_q;
  logic [AGGR_WIDTH-2:0] paggr_d, paggr_q;
  logic [ID_WIDTH-1:0]   pid_d, pid_q;

  logic [N_IDS-1:0] pend;
  logic [N_IDS-1:0] gnt;
  logic             busy;

  always_comb begin : arrive
    logic                 ref_ok;
    logic                 open_st;
    logic [MAX_AGGR-1:0]  ref_aggr;
    logic [MAX_AGGR-1:0]  req_aggr;
    logic [MAX_PORTS-1:0] acc;
    rec_mid = rec_q;
    wake_d  = '0;
    err_d   = '0;
    pend    = '0;
    busy    = 1'b0;
    for (int i = 0; i < N_IDS; i++) begin
      ref_ok   = rec_q[i].state == ST_COLLECT;
      open_st  = ref_ok || rec_q[i].state == ST_IDLE;
      ref_aggr = rec_q[i].aggr;
      acc      = '0;
      for (int p = 0; p < N_PORTS; p++) begin
        req_aggr = MAX_AGGR'(child_aggr_i[p]);
        if (child_sync_i[p] &&
            child_id_i[p] == ID_WIDTH'(i)) begin
          if (open_st && req_aggr != '0 &&
              !rec_q[i].mask[p] &&
              (!ref_ok || req_aggr == ref_aggr)) begin
            // first valid port of an idle id fixes the aggr
            if (!ref_ok) begin
              ref_ok   = 1'b1;
              ref_aggr = req_aggr;
            end
            acc[p] = 1'b1;
          end else begin
            err_d[p] = 1'b1;
          end
        end
      end
      if (acc != '0) begin
        rec_mid[i].state = ST_COLLECT;
        rec_mid[i].mask  = rec_q[i].mask | acc;
        rec_mid[i].aggr  = ref_aggr;
        if (rec_mid[i].mask == FULL) begin
          if (ref_aggr == MAX_AGGR'(1)) begin
            wake_d     = '1;
            rec_mid[i] = '0;
          end else begin
            rec_mid[i].state = ST_PEND;
          end
        end
      end
      if (rec_q[i].state == ST_WAIT) begin
        if (parent_error_i) begin
          err_d      = '1;
          rec_mid[i] = '0;
        end else if (parent_wake_i) begin
          wake_d     = '1;
          rec_mid[i] = '0;
        end
      end
      pend[i] = rec_mid[i].state == ST_PEND;
      busy    = busy || rec_mid[i].state == ST_WAIT;
    end
  end

  fractal_sync_arb #(
    .N (N_IDS)
  ) u_arb (
    .req_i (pend),
    .gnt_o (gnt)
  );

  always_comb begin : forward
    rec_d   = rec_mid;
    sync_d  = 1'b0;
    paggr_d = '0;
    pid_d   = '0;
    if (!busy) begin
      for (int i = 0; i < N_IDS; i++) begin
        if (gnt[i]) begin
          rec_d[i].state = ST_WAIT;
          sync_d  = 1'b1;
          paggr_d = rec_mid[i].aggr[AGGR_WIDTH-1:1];
          pid_d   = ID_WIDTH'(i);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_IDS; i++) begin
        rec_q[i] <= '0;
      end
      wake_q  <= '0;
      err_q   <= '0;
      sync_q  <= 1'b0;
      paggr_q <= '0;
      pid_q   <= '0;
    end else begin
      for (int i = 0; i < N_IDS; i++) begin
        rec_q[i] <= rec_d[i];
      end
      wake_q  <= wake_d;
      err_q   <= err_d;
      sync_q  <= sync_d;
      paggr_q <= paggr_d;
      pid_q   <= pid_d;
    end
  end

  assign child_wake_o  = wake_q;
  assign child_error_o = err_q;
  assign parent_sync_o = sync_q;
  assign parent_aggr_o = paggr_q;
  assign parent_id_o   = pid_q;

endmodule

// File: tb/tb_fractal_sync_node.sv
// Directed bench for fractal_sync_node with two ports,
// four ids and four-bit aggregation vectors.
module tb_fractal_sync_node;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic [1:0]      child_sync_i = '0;
  logic [1:0][3:0] child_aggr_i = '0;
  logic [1:0][1:0] child_id_i = '0;
  logic [1:0]      child_wake_o;
  logic [1:0]      child_error_o;
  logic            parent_sync_o;
  logic [2:0]      parent_aggr_o;
  logic [1:0]      parent_id_o;
  logic            parent_wake_i = 1'b0;
  logic            parent_error_i = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  fractal_sync_node #(
    .N_PORTS    (2),
    .AGGR_WIDTH (4),
    .ID_WIDTH   (2)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .child_sync_i   (child_sync_i),
    .child_aggr_i   (child_aggr_i),
    .child_id_i     (child_id_i),
    .child_wake_o   (child_wake_o),
    .child_error_o  (child_error_o),
    .parent_sync_o  (parent_sync_o),
    .parent_aggr_o  (parent_aggr_o),
    .parent_id_o    (parent_id_o),
    .parent_wake_i  (parent_wake_i),
    .parent_error_i (parent_error_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    child_sync_i   = '0;
    child_aggr_i   = '0;
    child_id_i     = '0;
    parent_wake_i  = 1'b0;
    parent_error_i = 1'b0;
  endtask

  task automatic req(input int p,
                     input logic [1:0] id,
                     input logic [3:0] aggr);
    child_sync_i[p] = 1'b1;
    child_id_i[p]   = id;
    child_aggr_i[p] = aggr;
  endtask

  task automatic outs(input string tag,
                      input logic [1:0] wake,
                      input logic [1:0] err,
                      input logic sync);
    chk({tag, "_wake"}, 32'(child_wake_o), 32'(wake));
    chk({tag, "_err"}, 32'(child_error_o), 32'(err));
    chk({tag, "_sync"}, 32'(parent_sync_o), 32'(sync));
  endtask

  task automatic fwd(input string tag,
                     input logic [2:0] aggr,
                     input logic [1:0] id);
    chk({tag, "_sync"}, 32'(parent_sync_o), 32'd1);
    chk({tag, "_paggr"}, 32'(parent_aggr_o), 32'(aggr));
    chk({tag, "_pid"}, 32'(parent_id_o), 32'(id));
  endtask

  initial begin
    // reset state
    idle();
    tick();
    outs("rst", 2'b00, 2'b00, 1'b0);
    chk("rst_paggr", 32'(parent_aggr_o), 32'd0);
    chk("rst_pid", 32'(parent_id_o), 32'd0);
    rst_ni = 1'b1;
    tick();

    // local root barrier, second arrival two cycles later
    req(0, 2'd1, 4'b0001);
    tick();
    outs("loc_a0", 2'b00, 2'b00, 1'b0);
    idle();
    tick();
    tick();
    req(1, 2'd1, 4'b0001);
    tick();
    outs("loc_a1", 2'b11, 2'b00, 1'b0);
    idle();
    tick();
    outs("loc_post", 2'b00, 2'b00, 1'b0);

    // forwarded barrier, parent wake later
    req(0, 2'd2, 4'b0110);
    req(1, 2'd2, 4'b0110);
    tick();
    fwd("up2", 3'b011, 2'd2);
    chk("up2_wake", 32'(child_wake_o), 32'd0);
    idle();
    tick();
    chk("up2_pulse", 32'(parent_sync_o), 32'd0);
    tick();
    tick();
    tick();
    parent_wake_i = 1'b1;
    tick();
    outs("up2_wk", 2'b11, 2'b00, 1'b0);
    idle();
    tick();
    chk("up2_wk_pulse", 32'(child_wake_o), 32'd0);

    // duplicate arrival from port0
    req(0, 2'd0, 4'b0001);
    tick();
    outs("dup_a0", 2'b00, 2'b00, 1'b0);
    req(0, 2'd0, 4'b0001);
    tick();
    outs("dup_a0b", 2'b00, 2'b01, 1'b0);
    idle();
    req(1, 2'd0, 4'b0001);
    tick();
    outs("dup_a1", 2'b11, 2'b00, 1'b0);
    idle();

    // ids 0 and 3 become pending together
    req(0, 2'd0, 4'b0010);
    req(1, 2'd3, 4'b0100);
    tick();
    outs("arb_a", 2'b00, 2'b00, 1'b0);
    idle();
    req(0, 2'd3, 4'b0100);
    req(1, 2'd0, 4'b0010);
    tick();
    fwd("arb_id0", 3'b001, 2'd0);
    idle();
    tick();
    chk("arb_hold", 32'(parent_sync_o), 32'd0);
    tick();
    chk("arb_hold2", 32'(parent_sync_o), 32'd0);
    parent_wake_i = 1'b1;
    tick();
    chk("arb_wk0", 32'(child_wake_o), 32'b11);
    fwd("arb_id3", 3'b010, 2'd3);
    idle();
    tick();
    chk("arb_id3_pulse", 32'(parent_sync_o), 32'd0);
    parent_wake_i = 1'b1;
    tick();
    outs("arb_wk3", 2'b11, 2'b00, 1'b0);
    idle();

    // parent error wins over wake
    req(0, 2'd1, 4'b0100);
    req(1, 2'd1, 4'b0100);
    tick();
    fwd("perr_up", 3'b010, 2'd1);
    idle();
    tick();
    parent_error_i = 1'b1;
    parent_wake_i  = 1'b1;
    tick();
    outs("perr", 2'b00, 2'b11, 1'b0);
    idle();

    // wake without outstanding barrier is ignored
    parent_wake_i = 1'b1;
    tick();
    outs("stray_wk", 2'b00, 2'b00, 1'b0);
    idle();

    // zero aggr request
    req(1, 2'd2, 4'b0000);
    tick();
    outs("zero_aggr", 2'b00, 2'b10, 1'b0);
    idle();

    // differing aggr in one cycle, port0 wins
    req(0, 2'd0, 4'b0001);
    req(1, 2'd0, 4'b0010);
    tick();
    outs("diff", 2'b00, 2'b10, 1'b0);
    idle();
    req(1, 2'd0, 4'b0001);
    tick();
    outs("diff_done", 2'b11, 2'b00, 1'b0);
    idle();

    // reset mid-barrier
    req(0, 2'd1, 4'b0001);
    tick();
    idle();
    req(0, 2'd2, 4'b0010);
    req(1, 2'd2, 4'b0010);
    tick();
    fwd("mr_up", 3'b001, 2'd2);
    idle();
    #2;
    rst_ni = 1'b0;
    #1;
    outs("mr_rst", 2'b00, 2'b00, 1'b0);
    chk("mr_paggr", 32'(parent_aggr_o), 32'd0);
    chk("mr_pid", 32'(parent_id_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    parent_wake_i = 1'b1;
    tick();
    outs("mr_wk", 2'b00, 2'b00, 1'b0);
    idle();
    req(1, 2'd1, 4'b0001);
    tick();
    outs("mr_id1", 2'b00, 2'b00, 1'b0);
    idle();
    req(0, 2'd1, 4'b0001);
    tick();
    outs("mr_id1_done", 2'b11, 2'b00, 1'b0);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
